// File: rtl/shift_add_mult.sv
// 4x4 unsigned shift-and-add multiplier: one partial-sum add per RUN cycle, 4 RUN + 1 DONE.
// Also holds the 4-bit ripple-carry adder that forms each partial sum.

module adder (
  input  logic [3:0] input1,
  input  logic [3:0] input2,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = input1[i] ^ input2[i] ^ carry[i];
    assign carry[i+1] = (input1[i] & input2[i]) | (carry[i] & (input1[i] ^ input2[i]));
  end

  assign carry_out = carry[4];

endmodule

module shift_add_mult (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] q_q, q_d;
  logic [3:0] p_hi_q, p_hi_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;

  logic [3:0] addend;
  logic [3:0] sum;
  logic       carry_out;
  logic [7:0] shifted;

  assign addend = q_q[0] ? a_q : 4'h0;

  adder u_adder (
    .input1    (p_hi_q),
    .input2    (addend),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // Right shift of {carry, sum, Q} by one; the dropped bit is the consumed multiplier LSB.
  assign shifted = {carry_out, sum, q_q[3:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    p_hi_d    = p_hi_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = multiplicand;
          q_d     = multiplier;
          p_hi_d  = 4'h0;
          cnt_d   = 2'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        p_hi_d = shifted[7:4];
        q_d    = shifted[3:0];
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = shifted;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= 4'h0;
      q_q       <= 4'h0;
      p_hi_q    <= 4'h0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      p_hi_q    <= p_hi_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule
